// File: rtl/riscv_imem_loader.sv
// Boot-time instruction memory loader.
// Receives a framed byte stream (4-byte little-endian word count, N data
// words sent little-endian, 1 XOR checksum byte), writes each completed
// word to the IMEM write port and releases the core reset only after a
// clean load.
//
// Byte handshake: a byte is transferred on a rising clock edge where
// i_rx_valid and o_rx_ready are both high. o_rx_ready is high only in
// LEN/DATA/CSUM while i_abort is low. The sender holds i_rx_data stable
// while i_rx_valid is high and the byte has not yet been accepted.
module riscv_imem_loader #(
  parameter int P_XLEN     = 32,
  parameter int P_ADDR_BIT = 12,
  parameter int P_TIMEOUT  = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic                    o_imem_we,
  output logic [P_ADDR_BIT-3:0]   o_imem_waddr,
  output logic [P_XLEN-1:0]       o_imem_wdata,
  output logic                    o_core_rstn,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic [2:0]              o_dbg_state
);

  localparam int AW  = P_ADDR_BIT - 2;
  localparam int BPW = P_XLEN / 8;

  // Largest legal word count: the whole IMEM.
  localparam logic [31:0] DEPTH          = 32'd1 << AW;
  localparam logic [2:0]  LAST_LEN_BYTE  = 3'd3;
  localparam logic [2:0]  LAST_DATA_BYTE = 3'(BPW - 1);
  localparam logic [15:0] TMO_LAST       = 16'(P_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_LEN  = 2'b01;
  localparam logic [1:0] E_CSUM = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  logic [2:0]         state_q,    state_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        len_q,      len_d;
  logic [AW-1:0]      word_idx_q, word_idx_d;
  // Holds the upper bytes received so far; the newest byte always lands on
  // top, so after a full word the first byte has shifted down to [7:0].
  logic [P_XLEN-9:0]  shift_q,    shift_d;
  logic [7:0]         csum_q,     csum_d;
  logic [15:0]        tmo_q,      tmo_d;
  logic               we_q,       we_d;
  logic [AW-1:0]      waddr_q,    waddr_d;
  logic [P_XLEN-1:0]  wdata_q,    wdata_d;
  logic [1:0]         err_code_q, err_code_d;

  logic               busy;
  logic               rx_ready;
  logic               accept;
  logic [31:0]        len_shift;
  logic [P_XLEN-1:0]  word_asm;

  assign busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign rx_ready  = busy && !i_abort;
  assign accept    = rx_ready && i_rx_valid;
  assign len_shift = {i_rx_data, len_q[31:8]};
  assign word_asm  = {i_rx_data, shift_q};

  // Next-state logic: abort overrides everything, then per-state framing, then idle timeout.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;

    if (i_abort) begin
      state_d    = S_IDLE;
      err_code_d = E_NONE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            state_d    = S_LEN;
            err_code_d = E_NONE;
            csum_d     = 8'd0;
            byte_cnt_d = 3'd0;
            word_idx_d = '0;
            len_d      = 32'd0;
            tmo_d      = 16'd0;
          end
        end
        S_LEN: begin
          if (accept) begin
            tmo_d      = 16'd0;
            len_d      = len_shift;
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == LAST_LEN_BYTE) begin
              byte_cnt_d = 3'd0;
              word_idx_d = '0;
              if ((len_shift == 32'd0) || (len_shift > DEPTH)) begin
                state_d    = S_ERR;
                err_code_d = E_LEN;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            tmo_d      = 16'd0;
            shift_d    = word_asm[P_XLEN-1:8];
            csum_d     = csum_q ^ i_rx_data;
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == LAST_DATA_BYTE) begin
              byte_cnt_d = 3'd0;
              we_d       = 1'b1;
              waddr_d    = word_idx_q;
              wdata_d    = word_asm;
              word_idx_d = word_idx_q + 1'b1;
              if (32'(word_idx_q) == (len_q - 32'd1)) begin
                state_d = S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            tmo_d = 16'd0;
            if (i_rx_data == csum_q) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_ERR;
              err_code_d = E_CSUM;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // A stalled stream while loading counts toward the timeout.
      if (busy && !accept) begin
        if (tmo_q == TMO_LAST) begin
          state_d    = S_ERR;
          err_code_d = E_TMO;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 3'd0;
      len_q      <= 32'd0;
      word_idx_q <= '0;
      shift_q    <= '0;
      csum_q     <= 8'd0;
      tmo_q      <= 16'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_code_q <= E_NONE;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_rx_ready   = rx_ready;
  assign o_busy       = busy;
  assign o_imem_we    = we_q;
  assign o_imem_waddr = waddr_q;
  assign o_imem_wdata = wdata_q;
  assign o_done       = (state_q == S_DONE);
  assign o_err        = (state_q == S_ERR);
  assign o_core_rstn  = (state_q == S_DONE);
  assign o_err_code   = err_code_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Bench for riscv_imem_loader: directed byte streams, expected IMEM writes
// queued by the stimulus and checked by an independent write monitor.
module tb_riscv_imem_loader;

  localparam int XLEN = 32;
  localparam int ABIT = 12;
  localparam int AW   = ABIT - 2;
  localparam int TMO  = 16;
  localparam int W    = AW + XLEN;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd2;

  logic              i_clk;
  logic              i_rstn;
  logic              i_start;
  logic              i_abort;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_rx_ready;
  logic              o_imem_we;
  logic [AW-1:0]     o_imem_waddr;
  logic [XLEN-1:0]   o_imem_wdata;
  logic              o_core_rstn;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [1:0]        o_err_code;
  logic [2:0]        o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [7:0]   tx_q[$];

  riscv_imem_loader #(
    .P_XLEN     (XLEN),
    .P_ADDR_BIT (ABIT),
    .P_TIMEOUT  (TMO)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_waddr (o_imem_waddr),
    .o_imem_wdata (o_imem_wdata),
    .o_core_rstn  (o_core_rstn),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every IMEM strobe must match the oldest queued expectation
  always @(negedge i_clk) begin
    if (i_rstn && o_imem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL imem_write: unexpected write addr 0x%0h data 0x%0h", o_imem_waddr, o_imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_imem_waddr, o_imem_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL imem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   o_imem_waddr, o_imem_wdata, mon_exp[W-1:XLEN], mon_exp[XLEN-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge i_clk);
      rdy = o_rx_ready;
      tick();
      n++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: byte 0x%0h not accepted within 50 cycles", b);
    end
    i_rx_valid = 1'b0;
  endtask

  // Sends tx_q with up to gap_max idle cycles before each byte; pulses
  // i_start just before byte index poke_idx (negative: never).
  task automatic send_tx(input int gap_max, input int poke_idx);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == poke_idx) begin
        pulse_start();
        check("T6 start ignored in DATA", o_dbg_state, ST_DATA);
      end
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      send_byte(tx_q[i]);
    end
  endtask

  task automatic wait_end(input string t);
    int n;
    n = 0;
    while (!(o_done || o_err) && n < 100) begin
      tick();
      n++;
    end
    check({t, " finished"}, o_done | o_err, 1);
  endtask

  task automatic check_result(input string t, input logic done, input logic err, input logic [1:0] code);
    check({t, " done"},      o_done,       done);
    check({t, " err"},       o_err,        err);
    check({t, " err_code"},  o_err_code,   code);
    check({t, " core_rstn"}, o_core_rstn,  done);
    check({t, " busy"},      o_busy,       0);
    check({t, " writes pending"}, exp_q.size(), 0);
  endtask

  task automatic queue_t2_writes();
    exp_q.push_back({10'd0, 32'h0000_0013});
    exp_q.push_back({10'd1, 32'h0010_0093});
  endtask

  // Stimulus sequence and final report
  initial begin
    int n;
    i_rstn     = 1'b0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    #12;
    check("reset state",     o_dbg_state, ST_IDLE);
    check("reset core_rstn", o_core_rstn, 0);
    check("reset outputs",   {o_rx_ready, o_imem_we, o_busy, o_done, o_err, o_err_code}, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();

    // T2: good two-word load; XOR of data bytes 13^93^10 = 0x90
    queue_t2_writes();
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
             8'h90};
    pulse_start();
    check("T2 busy after start", o_busy, 1);
    send_tx(0, -1);
    wait_end("T2");
    check_result("T2", 1, 0, 2'b00);
    check("T2 waddr hold", o_imem_waddr, 1);
    check("T2 wdata hold", o_imem_wdata, 32'h0010_0093);

    // T4: same stream, wrong checksum
    queue_t2_writes();
    tx_q[12] = 8'h81;
    pulse_start();
    check("T4 done cleared by start", o_done, 0);
    send_tx(0, -1);
    wait_end("T4");
    check_result("T4", 0, 1, 2'b10);

    // T3: word count one beyond depth, then zero
    tx_q = '{8'h01, 8'h04, 8'h00, 8'h00};
    pulse_start();
    send_tx(0, -1);
    wait_end("T3 len 0x401");
    check_result("T3 len 0x401", 0, 1, 2'b01);
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_tx(0, -1);
    wait_end("T3 len 0");
    check_result("T3 len 0", 0, 1, 2'b01);

    // Single-word load: EF^BE^AD^DE = 0x22
    exp_q.push_back({10'd0, 32'hDEAD_BEEF});
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    pulse_start();
    send_tx(0, -1);
    wait_end("N1");
    check_result("N1", 1, 0, 2'b00);

    // T5 timeout: stream stalls after 5 data bytes
    exp_q.push_back({10'd0, 32'h0000_0013});
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    pulse_start();
    send_tx(0, -1);
    n = 0;
    while (!o_err && n < 40) begin
      tick();
      n++;
    end
    check("T5 timeout idle cycles", n, TMO);
    check_result("T5 timeout", 0, 1, 2'b11);

    // T5 abort mid-word, then abort beating start
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    pulse_start();
    send_tx(0, -1);
    i_abort    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h55;
    #1;
    check("T5 abort ready", o_rx_ready, 0);
    tick();
    check("T5 abort state", o_dbg_state, ST_IDLE);
    check("T5 abort flags", {o_busy, o_done, o_err, o_core_rstn}, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("T5 abort beats start", o_dbg_state, ST_IDLE);
    i_abort    = 1'b0;
    i_rx_valid = 1'b0;
    tick();
    check("T5 idle after abort", {o_dbg_state, o_rx_ready}, 0);

    // T6: random gaps on i_rx_valid, i_start pulsed during DATA
    queue_t2_writes();
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
             8'h90};
    pulse_start();
    send_tx(3, 6);
    wait_end("T6");
    check_result("T6", 1, 0, 2'b00);

    // T1: asynchronous reset in the middle of DATA
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    pulse_start();
    send_tx(0, -1);
    #3;
    i_rstn = 1'b0;
    #1;
    check("T1 state", o_dbg_state, ST_IDLE);
    check("T1 core_rstn", o_core_rstn, 0);
    check("T1 flags", {o_rx_ready, o_imem_we, o_busy, o_done, o_err, o_err_code}, 0);
    check("T1 waddr", o_imem_waddr, 0);
    check("T1 wdata", o_imem_wdata, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
    check("T1 idle after reset", o_dbg_state, ST_IDLE);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
